// File: rtl/output_spi_stream_if.sv
// output_spi_stream_if: valid/ready word stream that feeds output_spi_stream.
//   data   word to transmit (WORD_W bits)
//   valid  data holds a word
//   ready  sink can accept; a word transfers when valid & ready at a rising clk edge
interface output_spi_stream_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] data;
   logic              valid;
   logic              ready;
   modport master (output data, valid, input ready);
   modport slave  (input data, valid, output ready);
endinterface

// File: rtl/output_spi_stream.sv
// output_spi_stream: multi-lane SPI transmit serializer with an input FIFO.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_in       word stream in (data/valid/ready)
//   o_out      LANES serial data lines, out[LANES-1] is the beat's most significant bit
//   o_clk_out  SPI clock, idle low, receiver samples on its rising edge
//   o_en_out   frame enable, active high
//   o_busy     FSM not idle or FIFO not empty
//   o_level    words held in the FIFO
module output_spi_stream #(
   parameter int WORD_W     = 8,
   parameter int LANES      = 4,
   parameter int DIV        = 2,
   parameter int FIFO_DEPTH = 4,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output_spi_stream_if.slave                 s_in,
   output logic [LANES-1:0]                   o_out,
   output logic                               o_clk_out,
   output logic                               o_en_out,
   output logic                               o_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level
);
   localparam int BEATS = WORD_W / LANES;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = $clog2(FIFO_DEPTH + 1);
   localparam int DW    = $clog2(DIV + 1);
   localparam int BW    = $clog2(BEATS + 1);
   localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);
   localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BLAST = BW'(BEATS - 1);

   if (LANES < 1 || WORD_W % LANES != 0) begin : g_err_lanes
      $error("output_spi_stream: WORD_W must be a positive multiple of LANES");
   end
   if (DIV < 1) begin : g_err_div
      $error("output_spi_stream: DIV must be at least 1");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
      $error("output_spi_stream: FIFO_DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

   state_t            r_state, w_state;
   logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [LW-1:0]     r_level;
   logic [WORD_W-1:0] r_shift, w_shift, w_head, w_next;
   logic [DW-1:0]     r_div, w_div;
   logic [BW-1:0]     r_beat, w_beat;
   logic [LANES-1:0]  r_out, w_out;
   logic              r_clk, w_clk, r_en, w_en;
   logic              w_push, w_pop, w_end, w_avail;

   // Beat 0 of a word; later beats are reached by shifting the word toward this position.
   function automatic logic [LANES-1:0] f_beat(input logic [WORD_W-1:0] w);
      return MSB_FIRST ? w[WORD_W-1 -: LANES] : w[LANES-1:0];
   endfunction

   assign s_in.ready = r_level != FULL;
   assign w_push     = s_in.valid && s_in.ready;
   assign w_avail    = r_level != '0;
   assign w_head     = r_mem[r_rptr];
   assign w_end      = r_div == DLAST;
   assign w_next     = MSB_FIRST ? r_shift << LANES : r_shift >> LANES;
   assign o_out      = r_out;
   assign o_clk_out  = r_clk;
   assign o_en_out   = r_en;
   assign o_level    = r_level;
   assign o_busy     = (r_state != IDLE) || w_avail;

   always_comb begin
      w_state = r_state;
      w_div   = (r_state == IDLE || w_end) ? '0 : r_div + DW'(1);
      w_shift = r_shift;
      w_beat  = r_beat;
      w_out   = r_out;
      w_clk   = r_clk;
      w_en    = r_en;
      w_pop   = 1'b0;
      case (r_state)
         IDLE: if (w_avail) begin
            w_pop   = 1'b1;
            w_shift = w_head;
            w_beat  = '0;
            w_out   = f_beat(w_head);
            w_en    = 1'b1;
            w_state = LOW;
         end
         LOW: if (w_end) begin
            w_clk   = 1'b1;
            w_state = HIGH;
         end
         HIGH: if (w_end) begin
            w_clk   = 1'b0;
            w_state = LOW;
            if (r_beat != BLAST) begin
               w_shift = w_next;
               w_beat  = r_beat + BW'(1);
               w_out   = f_beat(w_next);
            end else if (w_avail) begin
               // next word follows directly, keeping the frame open
               w_pop   = 1'b1;
               w_shift = w_head;
               w_beat  = '0;
               w_out   = f_beat(w_head);
            end else begin
               w_state = TAIL;
            end
         end
         TAIL: if (w_end) begin
            w_en    = 1'b0;
            w_out   = '0;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_shift <= '0;
         r_div   <= '0;
         r_beat  <= '0;
         r_out   <= '0;
         r_clk   <= 1'b0;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_state;
         r_wptr  <= r_wptr + AW'(w_push);
         r_rptr  <= r_rptr + AW'(w_pop);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
         r_shift <= w_shift;
         r_div   <= w_div;
         r_beat  <= w_beat;
         r_out   <= w_out;
         r_clk   <= w_clk;
         r_en    <= w_en;
      end
   end

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= s_in.data;
   end
endmodule

// File: tb/tb_output_spi_stream.sv
// tb_output_spi_stream: scoreboard bench for output_spi_stream.
//   Instance a: defaults (quad lanes, DIV=2, MSB first); instance b: single lane, DIV=1, LSB first.
module tb_output_spi_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   output_spi_stream_if #(.WORD_W(8)) a_if ();
   output_spi_stream_if #(.WORD_W(8)) b_if ();

   logic [3:0] a_out;
   logic [0:0] b_out;
   logic       a_clk, a_en, a_busy, b_clk, b_en, b_busy;
   logic [2:0] a_lvl, b_lvl;

   output_spi_stream #(.WORD_W(8), .LANES(4), .DIV(2), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .s_in(a_if), .o_out(a_out), .o_clk_out(a_clk),
      .o_en_out(a_en), .o_busy(a_busy), .o_level(a_lvl));

   output_spi_stream #(.WORD_W(8), .LANES(1), .DIV(1), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .s_in(b_if), .o_out(b_out), .o_clk_out(b_clk),
      .o_en_out(b_en), .o_busy(b_busy), .o_level(b_lvl));

   logic [3:0] out_v [2];
   logic       clk_v [2];
   logic       en_v  [2];
   logic       busy_v[2];
   logic       rdy_v [2];
   logic [2:0] lvl_v [2];
   assign out_v[0]  = a_out;
   assign out_v[1]  = {3'b000, b_out};
   assign clk_v[0]  = a_clk;
   assign clk_v[1]  = b_clk;
   assign en_v[0]   = a_en;
   assign en_v[1]   = b_en;
   assign busy_v[0] = a_busy;
   assign busy_v[1] = b_busy;
   assign rdy_v[0]  = a_if.ready;
   assign rdy_v[1]  = b_if.ready;
   assign lvl_v[0]  = a_lvl;
   assign lvl_v[1]  = b_lvl;

   int checks = 0;
   int failures = 0;
   logic [3:0] qa[$];
   logic [3:0] qb[$];

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: beats of a word as the protocol defines them, one queue entry per clk_out rise.
   task automatic expect_word(input int d, input logic [7:0] w);
      int l;
      l = (d != 0) ? 1 : 4;
      for (int b = 0; b < 8 / l; b++) begin
         int sh;
         logic [3:0] v;
         sh = (d != 0) ? l * b : 8 - l * (b + 1);
         v = 4'((int'(w) >> sh) & ((1 << l) - 1));
         if (d != 0) qb.push_back(v); else qa.push_back(v);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int d, input logic [7:0] w, output int waited);
      waited = 0;
      if (d != 0) begin b_if.data = w; b_if.valid = 1'b1; end
      else begin a_if.data = w; a_if.valid = 1'b1; end
      while (!rdy_v[d] && waited < 200) begin @(negedge clk); waited++; end
      if (waited >= 200) check("send_timeout", waited, 0);
      else expect_word(d, w);
      @(negedge clk);
      if (d != 0) b_if.valid = 1'b0; else a_if.valid = 1'b0;
   endtask

   task automatic frame(input int d, input int exp_en, input int exp_rises);
      int n, c, r;
      logic p;
      n = 0; c = 0; r = 0; p = 1'b0;
      while (!en_v[d] && n < 200) begin @(negedge clk); n++; end
      check("frame_start", int'(n < 200), 1);
      while (en_v[d] && c < 1000) begin
         if (clk_v[d] && !p) r++;
         p = clk_v[d];
         c++;
         @(negedge clk);
      end
      check("en_len", c, exp_en);
      check("clk_rises", r, exp_rises);
      check("out_after_frame", out_v[d], 0);
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while ((busy_v[d] || en_v[d]) && n < 3000) begin @(negedge clk); n++; end
      check("idle_reached", int'(n < 3000), 1);
   endtask

   task automatic check_reset(input int d);
      check("rst_out", out_v[d], 0);
      check("rst_clk_out", clk_v[d], 0);
      check("rst_en_out", en_v[d], 0);
      check("rst_busy", busy_v[d], 0);
      check("rst_level", lvl_v[d], 0);
      check("rst_ready", rdy_v[d], 1);
   endtask

   logic       pclk[2] = '{default: 1'b0};
   logic [3:0] pout[2] = '{default: 4'h0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n) begin
            if (clk_v[d] && !pclk[d]) begin
               int sz;
               logic [3:0] e;
               sz = (d != 0) ? qb.size() : qa.size();
               check("beat_expected", int'(sz > 0), 1);
               if (sz > 0) begin
                  e = (d != 0) ? qb.pop_front() : qa.pop_front();
                  check("beat_data", out_v[d], e);
               end
            end
            if (clk_v[d]) check("hold_while_high", {en_v[d], out_v[d]}, {1'b1, pout[d]});
            check("ready_vs_level", rdy_v[d], int'(lvl_v[d] != 3'd4));
         end
         pclk[d] <= clk_v[d];
         pout[d] <= out_v[d];
      end
   end

   initial begin
      int w, w2, maxw, n, act;
      a_if.valid = 1'b0; a_if.data = '0;
      b_if.valid = 1'b0; b_if.data = '0;
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      @(negedge clk);

      send(0, 8'hA5, w);
      frame(0, 10, 2);
      check("a5_busy_after", busy_v[0], 0);

      fork
         for (int i = 0; i < 4; i++) begin
            send(0, 8'(i), w2);
            check("burst_ready_held", w2, 0);
         end
         frame(0, 34, 8);
      join
      check("burst_drained", qa.size(), 0);

      maxw = 0;
      fork
         for (int i = 0; i < 6; i++) begin
            send(0, 8'(8'h17 * (i + 1)), w2);
            if (w2 > maxw) maxw = w2;
         end
         frame(0, 50, 12);
      join
      check("backpressure_seen", int'(maxw > 0), 1);
      check("six_drained", qa.size(), 0);

      send(1, 8'h01, w);
      frame(1, 17, 8);

      fork
         for (int i = 0; i < 24; i++) begin
            int wa;
            send(0, 8'($urandom), wa);
            repeat ($urandom_range(0, 14)) @(negedge clk);
         end
         for (int i = 0; i < 10; i++) begin
            int wb;
            send(1, 8'($urandom), wb);
            repeat ($urandom_range(0, 20)) @(negedge clk);
         end
      join
      wait_idle(0);
      wait_idle(1);
      check("random_a_drained", qa.size(), 0);
      check("random_b_drained", qb.size(), 0);

      send(0, 8'hA5, w);
      n = 0;
      while (!clk_v[0] && n < 100) begin @(negedge clk); n++; end
      check("first_rise_seen", clk_v[0], 1);
      #3 rst_n = 1'b0;
      #1;
      check_reset(0);
      qa.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (20) begin
         @(negedge clk);
         if (clk_v[0] || en_v[0] || lvl_v[0] != 3'd0) act++;
      end
      check("post_reset_quiet", act, 0);
      check("post_reset_level", lvl_v[0], 0);
      check("final_qa_empty", qa.size(), 0);
      check("final_qb_empty", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
